// File: rtl/pkt_link_pkg.sv
// ============================================================================
// pkt_link_pkg
// Shared state encodings and counter widths for the packet link controller.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package pkt_link_pkg;

    // Width of the RX byte counter and the TX burst counter
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_LOAD   = 3'd1,
        RX_STORE  = 3'd2,
        RX_WAITCS = 3'd3,
        RX_XFER   = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_ARM   = 2'd1,
        TX_SHIFT = 2'd2
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/pkt_link_ctrl_timeout.sv
// ============================================================================
// link_timeout
// Load/enable counter that flags expiry once it has counted TO_CYCLES-1.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module link_timeout #(
    parameter int TO_W      = 16,
    parameter int TO_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] C_LAST = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] cnt_q;

    // Restart on load, otherwise count while enabled
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/pkt_link_ctrl.sv
// ============================================================================
// pkt_link_ctrl
// RX/TX sequencing controller between RF shift path, packet register, SPI
// slave and TX buffer, with SPI stall timeout and sticky status flags.
// All control outputs are registered, so each pulse appears one cycle after
// the condition that causes it (tx_en likewise trails sh_en by one cycle).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_link_ctrl
    import pkt_link_pkg::*;
#(
    parameter int PKT_BYTES = 3,
    parameter int BYTE_W    = 8,
    parameter int TX_BURST  = 4,
    parameter int TO_W      = 16,
    parameter int TO_CYCLES = 50000
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             rx_mode_i,
    input  logic             cfg_mode_i,
    input  logic             pkt_rec_i,
    input  logic             cs_sync_i,
    input  logic             spi_out_rdy_i,
    input  logic             sh_en_i,
    input  logic             sh_en_done_i,
    input  logic             sts_clr_i,
    output logic             pkt_ld_o,
    output logic             spi_ld_o,
    output logic             pkt_en_o,
    output logic             pkt_rst_o,
    output logic             tx_ld_o,
    output logic             tx_sh_o,
    output logic             tx_en_o,
    output logic [CNT_W-1:0] bytes_left_o,
    output logic [CNT_W-1:0] tx_count_o,
    output logic             ovf_flg_o,
    output logic             to_flg_o
);

    localparam int               BIT_W        = $clog2(BYTE_W + 1);
    localparam logic [BIT_W-1:0] C_BYTE_W     = BIT_W'(BYTE_W);
    localparam logic [CNT_W-1:0] C_PKT_BYTES  = CNT_W'(PKT_BYTES);
    localparam logic [CNT_W-1:0] C_TX_BURST   = CNT_W'(TX_BURST);

    rx_state_t        rx_state_q;
    tx_state_t        tx_state_q;
    logic             pkt_rec_q;
    logic [CNT_W-1:0] bytes_left_q;
    logic [CNT_W-1:0] tx_count_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic             pkt_ld_q, spi_ld_q, pkt_en_q, pkt_rst_q;
    logic             tx_ld_q, tx_sh_q, tx_en_q;
    logic             ovf_flg_q, to_flg_q;

    logic             pkt_rise;
    logic             rx_run;
    logic             tx_run;
    logic             to_expire;
    logic [CNT_W-1:0] bytes_left_d;
    logic [CNT_W-1:0] tx_count_d;

    assign pkt_rise     = pkt_rec_i & ~pkt_rec_q;
    assign rx_run       = ~cfg_mode_i & rx_mode_i;
    assign tx_run       = ~cfg_mode_i & ~rx_mode_i;
    assign bytes_left_d = bytes_left_q - 1'b1;
    assign tx_count_d   = tx_count_q + 1'b1;

    // Edge-detect register runs every cycle, even while frozen
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pkt_rec_q <= 1'b0;
        end else begin
            pkt_rec_q <= pkt_rec_i;
        end
    end

    link_timeout #(
        .TO_W      (TO_W),
        .TO_CYCLES (TO_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load_i   (rx_run && (rx_state_q == RX_STORE)),
        .en_i     (rx_run && (rx_state_q == RX_WAITCS) && cs_sync_i),
        .expire_o (to_expire)
    );

    // RX sequencer: packet capture, SPI hand-off, timeout and overrun flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_state_q   <= RX_IDLE;
            bytes_left_q <= '0;
            pkt_ld_q     <= 1'b0;
            spi_ld_q     <= 1'b0;
            pkt_en_q     <= 1'b0;
            pkt_rst_q    <= 1'b0;
            ovf_flg_q    <= 1'b0;
            to_flg_q     <= 1'b0;
        end else begin
            pkt_ld_q  <= 1'b0;
            spi_ld_q  <= 1'b0;
            pkt_en_q  <= 1'b0;
            pkt_rst_q <= 1'b0;
            // Clear first so that a set later in this block wins
            if (sts_clr_i) begin
                ovf_flg_q <= 1'b0;
                to_flg_q  <= 1'b0;
            end
            if (cfg_mode_i) begin
                rx_state_q <= rx_state_q;
            end else if (!rx_mode_i) begin
                rx_state_q <= RX_IDLE;
            end else begin
                // A packet arriving while a previous one is in flight is dropped
                if (pkt_rise && (rx_state_q != RX_LOAD)) begin
                    ovf_flg_q <= 1'b1;
                end
                case (rx_state_q)
                    RX_IDLE: begin
                        rx_state_q <= RX_LOAD;
                    end
                    RX_LOAD: begin
                        bytes_left_q <= C_PKT_BYTES;
                        if (pkt_rise) begin
                            pkt_ld_q   <= 1'b1;
                            spi_ld_q   <= 1'b1;
                            rx_state_q <= RX_STORE;
                        end
                    end
                    RX_STORE: begin
                        pkt_rst_q  <= 1'b1;
                        rx_state_q <= RX_WAITCS;
                    end
                    RX_WAITCS: begin
                        if (bytes_left_q == '0) begin
                            rx_state_q <= RX_LOAD;
                        end else if (!cs_sync_i) begin
                            rx_state_q <= RX_XFER;
                        end else if (to_expire) begin
                            to_flg_q     <= 1'b1;
                            bytes_left_q <= '0;
                            rx_state_q   <= RX_LOAD;
                        end
                    end
                    RX_XFER: begin
                        if (cs_sync_i) begin
                            pkt_en_q     <= 1'b1;
                            bytes_left_q <= bytes_left_d;
                            rx_state_q   <= (bytes_left_d != '0) ? RX_STORE : RX_LOAD;
                        end
                    end
                    default: begin
                        rx_state_q <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    // TX sequencer: SPI byte -> TX buffer load, then bit shifting per byte
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state_q <= TX_IDLE;
            tx_count_q <= '0;
            bit_cnt_q  <= '0;
            tx_ld_q    <= 1'b0;
            tx_sh_q    <= 1'b0;
            tx_en_q    <= 1'b0;
        end else begin
            tx_ld_q <= 1'b0;
            tx_en_q <= 1'b0;
            if (cfg_mode_i) begin
                tx_state_q <= tx_state_q;
            end else if (!tx_run) begin
                tx_state_q <= TX_IDLE;
                tx_sh_q    <= 1'b0;
            end else begin
                case (tx_state_q)
                    TX_IDLE: begin
                        tx_count_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_sh_q    <= 1'b0;
                        if (!cs_sync_i) begin
                            tx_state_q <= TX_ARM;
                        end
                    end
                    TX_ARM: begin
                        if (spi_out_rdy_i) begin
                            tx_ld_q    <= 1'b1;
                            tx_sh_q    <= 1'b1;
                            tx_state_q <= TX_SHIFT;
                        end else if (cs_sync_i) begin
                            tx_state_q <= TX_IDLE;
                        end
                    end
                    TX_SHIFT: begin
                        // sh_en_done ends the byte early and suppresses that shift
                        if (sh_en_done_i || (bit_cnt_q == C_BYTE_W)) begin
                            tx_count_q <= tx_count_d;
                            bit_cnt_q  <= '0;
                            tx_sh_q    <= 1'b0;
                            if (!cs_sync_i && (tx_count_d < C_TX_BURST)) begin
                                tx_state_q <= TX_ARM;
                            end else begin
                                tx_state_q <= TX_IDLE;
                            end
                        end else begin
                            tx_en_q <= sh_en_i;
                            if (sh_en_i) begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        tx_state_q <= TX_IDLE;
                    end
                endcase
            end
        end
    end

    assign pkt_ld_o     = pkt_ld_q;
    assign spi_ld_o     = spi_ld_q;
    assign pkt_en_o     = pkt_en_q;
    assign pkt_rst_o    = pkt_rst_q;
    assign tx_ld_o      = tx_ld_q;
    assign tx_sh_o      = tx_sh_q;
    assign tx_en_o      = tx_en_q;
    assign bytes_left_o = bytes_left_q;
    assign tx_count_o   = tx_count_q;
    assign ovf_flg_o    = ovf_flg_q;
    assign to_flg_o     = to_flg_q;

endmodule

`default_nettype wire

// File: tb/tb_pkt_link_ctrl.sv
// ============================================================================
// tb_pkt_link_ctrl
// Directed bench for pkt_link_ctrl with hand-computed expected values.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pkt_link_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_mode = 1'b1, cfg_mode = 1'b0, pkt_rec = 1'b0, cs_sync = 1'b1;
    logic       spi_out_rdy = 1'b0, sh_en = 1'b0, sh_en_done = 1'b0, sts_clr = 1'b0;
    logic       pkt_ld, spi_ld, pkt_en, pkt_rst, tx_ld, tx_sh, tx_en, ovf_flg, to_flg;
    logic [3:0] bytes_left, tx_count;

    int n_total = 0;
    int n_bad   = 0;
    int c_pkt_ld = 0, c_spi_ld = 0, c_pkt_en = 0, c_pkt_rst = 0, c_tx_ld = 0, c_tx_en = 0;

    pkt_link_ctrl #(
        .PKT_BYTES (3),
        .BYTE_W    (8),
        .TX_BURST  (2),
        .TO_W      (16),
        .TO_CYCLES (20)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .rx_mode_i     (rx_mode),
        .cfg_mode_i    (cfg_mode),
        .pkt_rec_i     (pkt_rec),
        .cs_sync_i     (cs_sync),
        .spi_out_rdy_i (spi_out_rdy),
        .sh_en_i       (sh_en),
        .sh_en_done_i  (sh_en_done),
        .sts_clr_i     (sts_clr),
        .pkt_ld_o      (pkt_ld),
        .spi_ld_o      (spi_ld),
        .pkt_en_o      (pkt_en),
        .pkt_rst_o     (pkt_rst),
        .tx_ld_o       (tx_ld),
        .tx_sh_o       (tx_sh),
        .tx_en_o       (tx_en),
        .bytes_left_o  (bytes_left),
        .tx_count_o    (tx_count),
        .ovf_flg_o     (ovf_flg),
        .to_flg_o      (to_flg)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            c_pkt_ld  = c_pkt_ld  + int'(pkt_ld);
            c_spi_ld  = c_spi_ld  + int'(spi_ld);
            c_pkt_en  = c_pkt_en  + int'(pkt_en);
            c_pkt_rst = c_pkt_rst + int'(pkt_rst);
            c_tx_ld   = c_tx_ld   + int'(tx_ld);
            c_tx_en   = c_tx_en   + int'(tx_en);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are read 1ns after the edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_counts();
        c_pkt_ld = 0; c_spi_ld = 0; c_pkt_en = 0; c_pkt_rst = 0; c_tx_ld = 0; c_tx_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        tick(2);
        chk("rst_bytes_left", 32'(bytes_left), 0);
        chk("rst_pulses", 32'({pkt_ld, spi_ld, pkt_en, pkt_rst, tx_ld, tx_sh, tx_en}), 0);
        chk("rst_flags", 32'({ovf_flg, to_flg}), 0);
        rst_n = 1'b1;
        tick(2);    // IDLE -> LOAD, then LOAD loads bytes_left
        chk("load_bytes_left", 32'(bytes_left), 3);

        // ---------------- full RX packet ----------------
        clr_counts();
        pkt_rec = 1'b1;
        tick(1);
        chk("pkt_ld_latency", 32'(pkt_ld), 1);
        chk("spi_ld_latency", 32'(spi_ld), 1);
        for (int i = 0; i < 3; i++) begin
            cs_sync = 1'b0;
            tick(3);
            cs_sync = 1'b1;
            tick(1);
            chk("pkt_en_pulse", 32'(pkt_en), 1);
            chk("bytes_left_dec", 32'(bytes_left), 32'(2 - i));
        end
        tick(1);
        chk("back_in_load", 32'(bytes_left), 3);
        chk("rx_pkt_ld_cnt", 32'(c_pkt_ld), 1);
        chk("rx_spi_ld_cnt", 32'(c_spi_ld), 1);
        chk("rx_pkt_en_cnt", 32'(c_pkt_en), 3);
        chk("rx_pkt_rst_cnt", 32'(c_pkt_rst), 3);

        // ---------------- SPI timeout ----------------
        pkt_rec = 1'b0;
        tick(1);
        pkt_rec = 1'b1;
        tick(1);    // now in STORE
        tick(1);    // now in WAITCS, counter at 0
        tick(19);
        chk("to_flg_early", 32'(to_flg), 0);
        tick(1);
        chk("to_flg_set", 32'(to_flg), 1);
        chk("to_bytes_zero", 32'(bytes_left), 0);
        sts_clr = 1'b1;
        tick(1);
        sts_clr = 1'b0;
        chk("to_flg_clr", 32'(to_flg), 0);

        // ---------------- overrun during XFER ----------------
        clr_counts();
        pkt_rec = 1'b0;
        tick(1);
        pkt_rec = 1'b1;
        tick(1);
        cs_sync = 1'b0;
        tick(3);    // STORE -> WAITCS -> XFER
        pkt_rec = 1'b0;
        tick(1);
        chk("ovf_before", 32'(ovf_flg), 0);
        pkt_rec = 1'b1;
        tick(1);
        chk("ovf_set", 32'(ovf_flg), 1);
        chk("ovf_no_pkt_ld", 32'(c_pkt_ld), 1);

        // ---------------- config freeze mid-XFER ----------------
        cfg_mode = 1'b1;
        cs_sync  = 1'b1;
        tick(3);
        chk("cfg_no_pkt_en", 32'(c_pkt_en), 0);
        chk("cfg_bytes_hold", 32'(bytes_left), 3);
        cs_sync  = 1'b0;
        cfg_mode = 1'b0;
        tick(2);
        cs_sync = 1'b1;
        tick(1);
        chk("cfg_resume_pkt_en", 32'(pkt_en), 1);
        chk("cfg_resume_bytes", 32'(bytes_left), 2);

        // ---------------- TX burst of 2 ----------------
        rx_mode = 1'b0;
        pkt_rec = 1'b0;
        tick(2);
        clr_counts();
        cs_sync = 1'b0;
        tick(2);    // TX_IDLE -> TX_ARM
        for (int b = 0; b < 2; b++) begin
            spi_out_rdy = 1'b1;
            tick(1);
            spi_out_rdy = 1'b0;
            chk("tx_ld_pulse", 32'(tx_ld), 1);
            chk("tx_sh_on", 32'(tx_sh), 1);
            sh_en = 1'b1;
            tick(8);
            sh_en = 1'b0;
            tick(1);
            chk("tx_count_byte", 32'(tx_count), 32'(b + 1));
            chk("tx_sh_off", 32'(tx_sh), 0);
        end
        // burst full: FSM is idle, this third byte is ignored
        spi_out_rdy = 1'b1;
        tick(1);
        spi_out_rdy = 1'b0;
        tick(1);
        chk("tx_ld_total", 32'(c_tx_ld), 2);
        chk("tx_en_total", 32'(c_tx_en), 16);
        chk("tx_count_cleared", 32'(tx_count), 0);
        cs_sync = 1'b1;
        tick(2);

        // ---------------- early byte end via sh_en_done ----------------
        cs_sync = 1'b0;
        tick(2);
        clr_counts();
        spi_out_rdy = 1'b1;
        tick(1);
        spi_out_rdy = 1'b0;
        sh_en = 1'b1;
        tick(4);
        sh_en_done = 1'b1;
        tick(1);
        sh_en = 1'b0;
        sh_en_done = 1'b0;
        chk("done_tx_en_low", 32'(tx_en), 0);
        chk("done_tx_en_cnt", 32'(c_tx_en), 4);
        chk("done_tx_count", 32'(tx_count), 1);
        spi_out_rdy = 1'b1;
        tick(1);
        spi_out_rdy = 1'b0;
        chk("done_rearmed", 32'(tx_ld), 1);

        // ---------------- asynchronous reset mid-shift ----------------
        sh_en = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #2;
        chk("async_rst_tx_sh", 32'(tx_sh), 0);
        chk("async_rst_tx_count", 32'(tx_count), 0);
        chk("async_rst_tx_en", 32'(tx_en), 0);
        sh_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
